// File: rtl/seq_shift_add_multiplier.sv
// Unsigned N x N -> 2N sequential shift-and-add multiplier.
// A single N-bit ripple adder is reused on every RUN cycle.

module ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1]   = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[N];

endmodule

module seq_shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [N-1:0]   mcand;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   mplr;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] shifted;
  logic           last_step;

  assign addend    = mplr[0] ? mcand : '0;
  assign last_step = (cnt == LAST);

  ripple_adder #(.N(N)) u_adder (
    .x    (acc_hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry-out becomes the new MSB, so the 2N+1-bit right shift loses nothing.
  assign shifted = {cout, sum, mplr[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc_hi  <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplr   <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= shifted[2*N-1:N];
          mplr   <= shifted[N-1:0];
          cnt    <= cnt + CW'(1);
          if (last_step) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: N=4 directed vectors and corner sequences, N=8 randomized
// products compared against plain a*b.

module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  vec_t vecs[8];

  int         rises[$];
  logic [7:0] prods[$];
  logic       prev_busy;
  int         done_seen;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.N(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  seq_shift_add_multiplier #(.N(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  // busy and done must never be asserted together on either instance
  always @(negedge clk) begin
    if (!rst) begin
      if (busy4 === 1'b1 && done4 === 1'b1) overlap++;
      if (busy8 === 1'b1 && done8 === 1'b1) overlap++;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one start pulse to the selected instance and wait (bounded) for done.
  task automatic applyStimulus(input int which, input logic [7:0] ta, input logic [7:0] tb,
                               output int lat, output int busy_cycles, output int hold_errs);
    logic        d, bz;
    logic [15:0] p, prev;
    prev = (which == 4) ? {8'h00, product4} : product8;
    if (which == 4) begin
      start4 = 1'b1; a4 = ta[3:0]; b4 = tb[3:0];
    end else begin
      start8 = 1'b1; a8 = ta; b8 = tb;
    end
    step();
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    lat = 1;
    busy_cycles = 0;
    hold_errs = 0;
    while (lat < 40) begin
      d  = (which == 4) ? done4 : done8;
      bz = (which == 4) ? busy4 : busy8;
      p  = (which == 4) ? {8'h00, product4} : product8;
      if (d) break;
      if (bz) busy_cycles++;
      if (p != prev) hold_errs++;
      step();
      lat++;
    end
  endtask

  task automatic runChecked(input int which, input logic [7:0] ta, input logic [7:0] tb,
                            input longint exp_prod, input string tag);
    int lat, bc, he;
    longint p;
    applyStimulus(which, ta, tb, lat, bc, he);
    p = (which == 4) ? longint'(product4) : longint'(product8);
    checkOutput($sformatf("%s latency", tag), lat, which + 1);
    checkOutput($sformatf("%s busy_cycles", tag), bc, which);
    checkOutput($sformatf("%s product", tag), p, exp_prod);
    checkOutput($sformatf("%s hold_during_run", tag), he, 0);
    step();
    checkOutput($sformatf("%s done_single", tag), (which == 4) ? done4 : done8, 0);
    checkOutput($sformatf("%s product_held", tag),
                (which == 4) ? longint'(product4) : longint'(product8), exp_prod);
  endtask

  initial begin
    vecs[0] = '{4'd13, 4'd11, 8'd143};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd9,  8'd0};
    vecs[3] = '{4'd9,  4'd0,  8'd0};
    vecs[4] = '{4'd1,  4'd1,  8'd1};
    vecs[5] = '{4'd15, 4'd1,  8'd15};
    vecs[6] = '{4'd8,  4'd2,  8'd16};
    vecs[7] = '{4'd7,  4'd9,  8'd63};

    // Reset held for two edges
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset busy4", busy4, 0);
    checkOutput("reset done4", done4, 0);
    checkOutput("reset product4", product4, 0);
    checkOutput("reset busy8", busy8, 0);
    checkOutput("reset product8", product8, 0);
    step();

    for (int i = 0; i < 8; i++)
      runChecked(4, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].prod,
                 $sformatf("vec%0d", i));

    // start held continuously: second operand pair only taken after DONE->IDLE
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    prev_busy = busy4;
    for (int k = 1; k <= 40 && prods.size() < 2; k++) begin
      step();
      if (busy4 && !prev_busy) rises.push_back(k);
      prev_busy = busy4;
      if (done4) begin
        prods.push_back(product4);
        a4 = 4'd7; b4 = 4'd2;
        if (prods.size() == 2) start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    checkOutput("held_start ops", prods.size(), 2);
    checkOutput("held_start accepts", rises.size(), 2);
    if (prods.size() == 2 && rises.size() == 2) begin
      checkOutput("held_start prod0", prods[0], 15);
      checkOutput("held_start prod1", prods[1], 14);
      checkOutput("held_start spacing", rises[1] - rises[0], 6);
    end
    step();
    step();

    // Abort mid-RUN with reset
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd10;
    step();
    start4 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort busy", busy4, 0);
    checkOutput("abort done", done4, 0);
    checkOutput("abort product", product4, 0);
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done4) done_seen++;
    end
    checkOutput("abort no_done", done_seen, 0);
    runChecked(4, 8'd2, 8'd3, 6, "after_abort");

    // N=8 corners then randomized products against a*b
    runChecked(8, 8'd255, 8'd255, 65025, "n8 max");
    runChecked(8, 8'd0, 8'd0, 0, "n8 zero");
    runChecked(8, 8'd255, 8'd1, 255, "n8 a_ones");
    runChecked(8, 8'd1, 8'd255, 255, "n8 b_ones");
    runChecked(8, 8'd128, 8'd2, 256, "n8 msb");
    for (int i = 0; i < 1200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      runChecked(8, ra, rb, longint'(ra) * longint'(rb), $sformatf("n8 rand%0d", i));
    end

    checkOutput("busy_done_exclusive", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
